// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path: digit-word layout and scanner FSM states.
package seg_pkg;

  localparam int unsigned SEG_VIS = 8;
  localparam int unsigned SEG_DP  = 7;
  localparam int unsigned SEG_MSB = 6;
  localparam int unsigned SEG_LSB = 0;

  typedef logic [8:0] seg_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Phase timer for the scanner: clearable up-counter flagging when it reaches the phase terminal count.
module seg_slot_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: walks the MUX select, blanks between digits, drives pins and frame pulse.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned CTRL_W         = 2,
  parameter int unsigned BLANK_CYC      = 4,
  parameter int unsigned SHOW_CYC       = 50000,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [8:0]          i_data,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic [N_DIGITS-1:0] o_an,
  output logic                o_frame
);

  localparam int unsigned MAX_CYC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);

  scan_state_t      state;
  seg_word_t        shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic             clr;

  // Polarity is applied only here, on the way into the pin registers.
  function automatic logic [6:0] seg_pins(input seg_word_t w);
    return (SEG_ACTIVE_LOW != 0) ? ~w[SEG_MSB:SEG_LSB] : w[SEG_MSB:SEG_LSB];
  endfunction

  function automatic logic dp_pin(input seg_word_t w);
    return (SEG_ACTIVE_LOW != 0) ? ~w[SEG_DP] : w[SEG_DP];
  endfunction

  function automatic logic [N_DIGITS-1:0] an_pins(input seg_word_t w, input logic [CTRL_W-1:0] sel);
    logic [N_DIGITS-1:0] oh;
    oh = w[SEG_VIS] ? (N_DIGITS'(1) << sel) : '0;
    return (AN_ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  assign term = (state == SHOW) ? CNT_W'(SHOW_CYC - 1) : CNT_W'(BLANK_CYC - 1);
  assign clr  = (state == IDLE) || !i_en || tc;

  seg_slot_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (clr),
    .run   (1'b1),
    .term  (term),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      o_ctrl  <= '0;
      o_frame <= 1'b0;
      o_an    <= AN_OFF;
      o_seg   <= SEG_OFF;
      o_dp    <= DP_OFF;
    end else begin
      // Pins default to dark; only SHOW cycles that continue in SHOW light them.
      o_frame <= 1'b0;
      o_an    <= AN_OFF;
      o_seg   <= SEG_OFF;
      o_dp    <= DP_OFF;
      if (!i_en) begin
        state  <= IDLE;
        o_ctrl <= '0;
      end else begin
        unique case (state)
          IDLE: state <= BLANK;
          BLANK: begin
            if (tc) begin
              shadow <= i_data;
              state  <= SHOW;
              o_seg  <= seg_pins(i_data);
              o_dp   <= dp_pin(i_data);
              o_an   <= an_pins(i_data, o_ctrl);
            end
          end
          SHOW: begin
            if (tc) begin
              state   <= BLANK;
              o_ctrl  <= (o_ctrl == CTRL_W'(N_DIGITS - 1)) ? '0 : o_ctrl + 1'b1;
              o_frame <= (o_ctrl == CTRL_W'(N_DIGITS - 1));
            end else begin
              o_seg <= seg_pins(shadow);
              o_dp  <= dp_pin(shadow);
              o_an  <= an_pins(shadow, o_ctrl);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a registered 4-entry MUX and a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int BLANK = 2;
  localparam int SHOW  = 4;
  localparam int SLOT  = BLANK + SHOW;
  localparam int NDIG  = 4;
  localparam int FRAME = NDIG * SLOT;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } pins_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [8:0] mux_q = 9'h000;
  logic [8:0] mem [NDIG];
  logic [1:0] ctrl;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  pins_t exp_q[$];

  // Reference model: time since scan start decides digit and phase.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [8:0] m_shadow = 9'h000;

  seg_scan_ctrl #(
    .N_DIGITS       (NDIG),
    .CTRL_W         (2),
    .BLANK_CYC      (BLANK),
    .SHOW_CYC       (SHOW),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_data  (mux_q),
    .o_ctrl  (ctrl),
    .o_seg   (seg),
    .o_dp    (dp),
    .o_an    (an),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mux_q <= mem[ctrl];

  function automatic bit mem_safe();
    return !m_active || (m_t % SLOT == 3);
  endfunction

  task automatic step(input logic r, input logic e, input bit mutate);
    pins_t exp;
    int    digit;
    int    phase;
    @(negedge clk);
    rst_n = r;
    en    = e;
    if (mutate && mem_safe()) begin
      for (int i = 0; i < NDIG; i++)
        if ($urandom_range(1, 0) == 1) mem[i] = 9'($urandom);
    end
    if (!r || (m_active && !e)) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_t = 0;
      end
    end else begin
      m_t++;
    end
    digit = (m_t / SLOT) % NDIG;
    phase = m_t % SLOT;
    if (m_active && phase == BLANK) m_shadow = mem[digit];
    exp.ctrl  = m_active ? 2'(digit) : 2'd0;
    exp.frame = m_active && m_t > 0 && (m_t % FRAME == 0);
    if (m_active && phase >= BLANK) begin
      exp.an  = m_shadow[8] ? ~(4'b0001 << digit) : 4'hF;
      exp.seg = ~m_shadow[6:0];
      exp.dp  = ~m_shadow[7];
    end else begin
      exp.an  = 4'hF;
      exp.seg = 7'h7F;
      exp.dp  = 1'b1;
    end
    exp_q.push_back(exp);
  endtask

  task automatic run_until_t(input int target);
    int guard = 0;
    while (!(m_active && m_t == target) && guard < 200) begin
      step(1'b1, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL run_until_t: model time %0d, required %0d", m_t, target);
    end
  endtask

  // Monitor: every cycle the DUT presents pins, compare against the oldest expectation.
  initial begin
    pins_t exp;
    pins_t act;
    forever begin
      @(posedge clk);
      #2;
      cycle++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = '{ctrl: ctrl, an: an, seg: seg, dp: dp, frame: frame};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL pins cycle %0d: ctrl=%0d an=%h seg=%h dp=%b frame=%b, required ctrl=%0d an=%h seg=%h dp=%b frame=%b",
                   cycle, act.ctrl, act.an, act.seg, act.dp, act.frame,
                   exp.ctrl, exp.an, exp.seg, exp.dp, exp.frame);
        end
      end
    end
  end

  initial begin
    mem[0] = 9'h13F;
    mem[1] = 9'h106;
    mem[2] = 9'h15B;
    mem[3] = 9'h14F;
    // Reset held with enable high.
    repeat (3) step(1'b0, 1'b1, 1'b0);
    // Three full frames: scan order, patterns, frame pulse.
    repeat (3 * FRAME) step(1'b1, 1'b1, 1'b0);
    // Invisible digit 2 and dp on digit 1, loaded while in reset.
    mem[1] = 9'h186;
    mem[2] = 9'h07F;
    step(1'b0, 1'b1, 1'b0);
    repeat (FRAME + 6) step(1'b1, 1'b1, 1'b0);
    // Enable drop during SHOW cycle 2 of digit 1, then re-enable.
    step(1'b0, 1'b1, 1'b0);
    run_until_t(SLOT + BLANK + 1);
    step(1'b1, 1'b0, 1'b0);
    repeat (SLOT * 2) step(1'b1, 1'b1, 1'b0);
    // Reset in the first BLANK cycle of digit 2, then restart.
    step(1'b0, 1'b1, 1'b0);
    run_until_t(2 * SLOT);
    step(1'b0, 1'b1, 1'b0);
    repeat (FRAME) step(1'b1, 1'b1, 1'b0);
    // Randomized run: sporadic enable drops and resets, digit data changing mid-SHOW.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(79, 0) != 0), ($urandom_range(39, 0) != 0), 1'b1);
    end
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
